// File: rtl/universal_shift_reg.sv
// universal_shift_reg: mode-selected shift/rotate/load register with an MSB-first serial transmit sequence
module universal_shift_reg #(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] parallel_in,
    input  logic             serial_in_lsb,
    input  logic             serial_in_msb,
    input  logic             start,
    output logic [WIDTH-1:0] parallel_out,
    output logic             serial_out_msb,
    output logic             serial_out_lsb,
    output logic             busy,
    output logic             done
);
    localparam int CW = $clog2(WIDTH);
    typedef enum logic {IDLE, SHIFT} state_t;
    state_t           state_q, state_d;
    logic [WIDTH-1:0] q_q, q_d, mode_val;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             done_q, done_d;
    always_comb begin
        mode_val = mode == 3'b001 ? {q_q[WIDTH-2:0], serial_in_lsb} :
                   mode == 3'b010 ? {serial_in_msb, q_q[WIDTH-1:1]} :
                   mode == 3'b011 ? parallel_in :
                   mode == 3'b100 ? {q_q[WIDTH-2:0], q_q[WIDTH-1]} :
                   mode == 3'b101 ? {q_q[0], q_q[WIDTH-1:1]} :
                   mode == 3'b110 ? '0 : q_q;
        state_d = state_q;
        q_d     = q_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        if (state_q == IDLE) begin
            if (start) begin
                q_d     = parallel_in;
                cnt_d   = CW'(WIDTH - 1);
                state_d = SHIFT;
            end else if (en) begin
                q_d = mode_val;
            end
        end else if (en) begin
            if (cnt_q != '0) begin
                q_d   = {q_q[WIDTH-2:0], serial_in_lsb};
                cnt_d = cnt_q - 1'b1;
            end else begin
                state_d = IDLE;
                done_d  = 1'b1;
            end
        end
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            q_q     <= RESET_VAL;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end
    assign parallel_out   = q_q;
    assign serial_out_msb = q_q[WIDTH-1];
    assign serial_out_lsb = q_q[0];
    assign busy           = state_q == SHIFT;
    assign done           = done_q;
endmodule
